// File: rtl/xy_route_alloc.sv
// xy_route_alloc: allocator and output stage for one output direction of a 2D-mesh router.
// Inputs whose head flit routes to OUT_DIR request the output; one is granted round-robin
// and owns the output until its tail flit passes. Flits pass through a single output
// register, giving one flit per cycle when downstream is ready.
//
// Optional feature: define ROUTER_YX_FIRST_EN for Y-first routing (X-first otherwise).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_tdata          REN flits, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_tvalid         per-input flit valid
//   in_tlast          per-input packet tail
//   in_tready         per-input accept (only the owner, only in LOCKED)
//   out_tdata         forwarded flit (registered)
//   out_tvalid        forwarded flit valid
//   out_tlast         forwarded flit is packet tail
//   out_tready        downstream accept
//   pkt_count         packets forwarded, wraps at 2^16
module xy_route_alloc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REN        = 5,
  parameter int unsigned CS         = 2,
  parameter int unsigned ROUTER_X   = 0,
  parameter int unsigned ROUTER_Y   = 0,
  parameter int unsigned OUT_DIR    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REN*DATA_WIDTH-1:0] in_tdata,
  input  logic [REN-1:0]            in_tvalid,
  input  logic [REN-1:0]            in_tlast,
  output logic [REN-1:0]            in_tready,
  output logic [DATA_WIDTH-1:0]     out_tdata,
  output logic                      out_tvalid,
  output logic                      out_tlast,
  input  logic                      out_tready,
  output logic [15:0]               pkt_count
);

  localparam int unsigned IW = (REN > 1) ? $clog2(REN) : 1;
  localparam logic [CS-1:0] RX  = CS'(ROUTER_X);
  localparam logic [CS-1:0] RY  = CS'(ROUTER_Y);
  localparam logic [2:0]    DIR = 3'(OUT_DIR);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;

  logic [REN-1:0]        req;
  logic                  grant_any;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         scan_idx;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_last;
  logic                  owner_valid;
  logic                  out_space;
  logic                  accept;

  // Output direction for a head flit's destination coordinates.
  function automatic logic [2:0] route(input logic [2*CS-1:0] dest);
    logic [CS-1:0] dx;
    logic [CS-1:0] dy;
    logic [2:0]    dir;
    dx = dest[CS-1:0];
    dy = dest[2*CS-1:CS];
`ifdef ROUTER_YX_FIRST_EN
    if (dy < RY)      dir = 3'd1;
    else if (dy > RY) dir = 3'd3;
    else if (dx > RX) dir = 3'd2;
    else if (dx < RX) dir = 3'd4;
    else              dir = 3'd0;
`else
    if (dx > RX)      dir = 3'd2;
    else if (dx < RX) dir = 3'd4;
    else if (dy < RY) dir = 3'd1;
    else if (dy > RY) dir = 3'd3;
    else              dir = 3'd0;
`endif
    return dir;
  endfunction

  // Requests are only meaningful in IDLE, where every presented flit is a head.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < REN; i++) begin
      req[i] = in_tvalid[i] && (route(in_tdata[i*DATA_WIDTH +: 2*CS]) == DIR);
    end
  end

  // First requester at or after rr_ptr, wrapping at REN.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < REN; k++) begin
      scan_idx = IW'((32'(rr_ptr_q) + k) % REN);
      if (!grant_any && req[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Owner flit mux.
  always_comb begin
    owner_data  = '0;
    owner_last  = 1'b0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < REN; i++) begin
      if (owner_q == IW'(i)) begin
        owner_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        owner_last  = in_tlast[i];
        owner_valid = in_tvalid[i];
      end
    end
  end

  assign out_space = !out_tvalid || out_tready;
  assign accept    = (state_q == StLocked) && owner_valid && out_space;

  always_comb begin
    in_tready = '0;
    for (int unsigned i = 0; i < REN; i++) begin
      if ((state_q == StLocked) && out_space && (owner_q == IW'(i))) begin
        in_tready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (accept) begin
        out_tdata  <= owner_data;
        out_tlast  <= owner_last;
        out_tvalid <= 1'b1;
      end else if (out_tready) begin
        out_tdata  <= '0;
        out_tlast  <= 1'b0;
        out_tvalid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          // The grant cycle itself accepts nothing; the head moves on the next cycle.
          if (grant_any) begin
            state_q <= StLocked;
            owner_q <= grant_idx;
          end
        end
        StLocked: begin
          if (accept && owner_last) begin
            state_q   <= StIdle;
            rr_ptr_q  <= (owner_q == IW'(REN - 1)) ? '0 : owner_q + 1'b1;
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xy_route_alloc.sv
// Bench for xy_route_alloc at router (1,1), OUT_DIR=2 (east), five inputs.
// A packet-level source per input feeds the DUT; a reference model predicts accepts,
// pushes expected flits into a scoreboard queue, and a monitor pops them as flits leave.
module tb_xy_route_alloc;
  localparam int DW  = 32;
  localparam int REN = 5;
  localparam int CS  = 2;
  localparam int RX  = 1;
  localparam int RY  = 1;
  localparam int DIR = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [REN*DW-1:0]   in_tdata = '0;
  logic [REN-1:0]      in_tvalid = '0;
  logic [REN-1:0]      in_tlast = '0;
  logic [REN-1:0]      in_tready;
  logic [DW-1:0]       out_tdata;
  logic                out_tvalid;
  logic                out_tlast;
  logic                out_tready = 1'b0;
  logic [15:0]         pkt_count;

  xy_route_alloc #(
    .DATA_WIDTH(DW), .REN(REN), .CS(CS), .ROUTER_X(RX), .ROUTER_Y(RY), .OUT_DIR(DIR)
  ) dut (
    .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tready(out_tready), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } flit_t;
  flit_t exp_q[$];

  // Sources
  int            rem[REN];
  bit            head[REN];
  bit            foreign_seen[REN];
  bit            pend_hs[REN];
  logic [DW-1:0] cur_data[REN];
  bit            auto_gen = 0;
  int            valid_pct = 100;
  int            ready_pct = 100;
  bit            rst_req = 1;

  // Reference model
  bit m_known = 0;
  bit m_locked = 0;
  int m_owner = 0;
  int m_rr = 0;
  bit m_full = 0;
  int m_cnt = 0;
  bit chk_rst_data = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_route(input logic [DW-1:0] d);
    int dx;
    int dy;
    dx = int'(d[CS-1:0]);
    dy = int'(d[2*CS-1:CS]);
`ifdef ROUTER_YX_FIRST_EN
    if (dy != RY) return (dy < RY) ? 1 : 3;
    if (dx != RX) return (dx > RX) ? 2 : 4;
`else
    if (dx != RX) return (dx > RX) ? 2 : 4;
    if (dy != RY) return (dy < RY) ? 1 : 3;
`endif
    return 0;
  endfunction

  task automatic new_pkt(input int i, input int dx, input int dy, input int len);
    logic [DW-1:0] d;
    d = $urandom;
    d[CS-1:0] = CS'(dx);
    d[2*CS-1:CS] = CS'(dy);
    cur_data[i] = d;
    rem[i] = len;
    head[i] = 1;
  endtask

  // One clock cycle: drive at negedge, check and advance the model just after.
  task automatic step();
    logic [REN-1:0] exp_ready;
    bit             space;
    bit             acc;
    int             j;
    @(negedge clk);
    for (int i = 0; i < REN; i++) begin
      if (pend_hs[i]) begin
        rem[i]--;
        head[i] = 0;
        if (rem[i] > 0) cur_data[i] = $urandom;
      end
      pend_hs[i] = 0;
      // A head bound elsewhere leaves after one presentation (another output took it).
      if (foreign_seen[i]) rem[i] = 0;
      foreign_seen[i] = 0;
      if (auto_gen && rem[i] == 0 && $urandom_range(0, 99) < 30)
        new_pkt(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
      in_tvalid[i] = (rem[i] > 0) && ($urandom_range(0, 99) < valid_pct);
      in_tdata[i*DW +: DW] = cur_data[i];
      in_tlast[i] = (rem[i] == 1);
      foreign_seen[i] = in_tvalid[i] && head[i] && (ref_route(cur_data[i]) != DIR);
    end
    out_tready = ($urandom_range(0, 99) < ready_pct);
    rst = rst_req;
    #1;
    space = !m_full || out_tready;
    if (m_known) begin
      exp_ready = '0;
      if (m_locked && space) exp_ready[m_owner] = 1'b1;
      check("in_tready", 64'(in_tready), 64'(exp_ready));
      check("out_tvalid", 64'(out_tvalid), 64'(m_full));
      check("pkt_count", 64'(pkt_count), 64'(16'(m_cnt)));
      if (chk_rst_data) begin
        check("reset_out_tdata", 64'(out_tdata), 64'd0);
        check("reset_out_tlast", 64'(out_tlast), 64'd0);
        chk_rst_data = 0;
      end
    end
    for (int i = 0; i < REN; i++) pend_hs[i] = in_tvalid[i] && in_tready[i] && !rst;
    if (rst) begin
      m_known = 1;
      m_locked = 0;
      m_rr = 0;
      m_full = 0;
      m_cnt = 0;
      chk_rst_data = 1;
      exp_q.delete();
      for (int i = 0; i < REN; i++) begin
        rem[i] = 0;
        pend_hs[i] = 0;
        foreign_seen[i] = 0;
      end
    end else begin
      acc = m_locked && in_tvalid[m_owner] && space;
      if (acc) exp_q.push_back({in_tlast[m_owner], in_tdata[m_owner*DW +: DW]});
      if (acc) m_full = 1;
      else if (out_tready) m_full = 0;
      if (m_locked) begin
        if (acc && in_tlast[m_owner]) begin
          m_locked = 0;
          m_rr = (m_owner + 1) % REN;
          m_cnt = (m_cnt + 1) % 65536;
        end
      end else begin
        for (int k = 0; k < REN; k++) begin
          j = (m_rr + k) % REN;
          if (!m_locked && in_tvalid[j] && ref_route(in_tdata[j*DW +: DW]) == DIR) begin
            m_locked = 1;
            m_owner = j;
          end
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  // Monitor: every flit handed downstream must be the next expected one.
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      #2;
      if (m_known && !rst && out_tvalid === 1'b1 && out_tready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out_flit: unexpected flit %0h, expected none", out_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", 64'(out_tdata), 64'(e.data));
          check("out_tlast", 64'(out_tlast), 64'(e.last));
        end
      end
    end
  end

  initial begin
    int budget;
    bit busy;
    for (int i = 0; i < REN; i++) begin
      rem[i] = 0;
      head[i] = 0;
      foreign_seen[i] = 0;
      pend_hs[i] = 0;
      cur_data[i] = '0;
    end

    // Reset
    rst_req = 1;
    steps(2);
    rst_req = 0;
    steps(2);

    // 3-flit packet from input 0 to (2,1)
    new_pkt(0, 2, 1, 3);
    steps(7);
    check("single_pkt_count", 64'(pkt_count), 64'd1);

    // Inputs 1 and 3 together from rr_ptr=0, then 0 and 4 together (rr_ptr should be 4)
    rst_req = 1;
    step();
    rst_req = 0;
    new_pkt(1, 3, 2, 2);
    new_pkt(3, 2, 3, 2);
    steps(9);
    new_pkt(0, 2, 0, 1);
    new_pkt(4, 3, 1, 1);
    steps(7);
    check("rr_pair_count", 64'(pkt_count), 64'd4);

    // Downstream stall for 4 cycles mid-packet
    new_pkt(2, 3, 3, 4);
    steps(3);
    ready_pct = 0;
    steps(4);
    ready_pct = 100;
    steps(5);
    check("stall_count", 64'(pkt_count), 64'd5);

    // Dest (2,0): east here under X-first, north under Y-first
    new_pkt(2, 2, 0, 2);
    steps(6);
`ifdef ROUTER_YX_FIRST_EN
    check("yx_dest_count", 64'(pkt_count), 64'd5);
`else
    check("xy_dest_count", 64'(pkt_count), 64'd6);
`endif

    // Reset after the 2nd of 4 flits, then a normal packet
    new_pkt(1, 2, 2, 4);
    steps(3);
    rst_req = 1;
    step();
    rst_req = 0;
    steps(1);
    check("rst_mid_count", 64'(pkt_count), 64'd0);
    new_pkt(1, 3, 0, 2);
    steps(5);
    check("post_rst_count", 64'(pkt_count), 64'd1);

    // Single-flit packet from input 4; rr_ptr wraps to 0 so input 0 beats input 1 next
    new_pkt(4, 2, 1, 1);
    steps(4);
    new_pkt(0, 3, 3, 1);
    new_pkt(1, 2, 2, 1);
    steps(6);
    check("single_flit_count", 64'(pkt_count), 64'd4);

    // Randomised traffic
    auto_gen = 1;
    valid_pct = 80;
    ready_pct = 70;
    steps(3000);

    // Drain
    auto_gen = 0;
    valid_pct = 100;
    ready_pct = 100;
    budget = 300;
    busy = 1;
    while (busy && budget > 0) begin
      step();
      budget--;
      busy = m_locked || (exp_q.size() != 0) || m_full;
      for (int i = 0; i < REN; i++) if (rem[i] != 0) busy = 1;
    end
    check("drain_done", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xy_route_alloc.md
XY_ROUTE_ALLOC -- requirements
Module: xy_route_alloc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 Parameter REN, default 5, number of input ports (router endpoints).
REQ-003 Parameter CS, default 2, bits per mesh coordinate.
REQ-004 Parameter ROUTER_X, default 0, X coordinate of this router.
REQ-005 Parameter ROUTER_Y, default 0, Y coordinate of this router.
REQ-006 Parameter OUT_DIR, default 0, direction served by this output (0 local, 1 north, 2 east, 3 south, 4 west).
REQ-007 clk  input  1  sole clock, all logic on rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 in_tdata  input  REN*DATA_WIDTH  per-input flit; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_tvalid  input  REN  per-input flit valid.
REQ-011 in_tlast  input  REN  per-input last flit of packet.
REQ-012 in_tready  output  REN  per-input flit accepted by this output.
REQ-013 out_tdata  output  DATA_WIDTH  forwarded flit.
REQ-014 out_tvalid  output  1  forwarded flit valid.
REQ-015 out_tlast  output  1  forwarded flit is packet tail.
REQ-016 out_tready  input  1  downstream accepts flit.
REQ-017 pkt_count  output  16  packets forwarded, wraps modulo 2^16.

Function
REQ-018 Head flit destination SHALL be dest_X = tdata[CS-1:0], dest_Y = tdata[2*CS-1:CS].
REQ-019 Route SHALL be X-first: dest_X>ROUTER_X -> 2; dest_X<ROUTER_X -> 4; else dest_Y<ROUTER_Y -> 1; dest_Y>ROUTER_Y -> 3; else 0.
REQ-020 Input i SHALL request in IDLE when in_tvalid[i] and route(in_tdata[i]) == OUT_DIR.
REQ-021 FSM states IDLE, LOCKED; IDLE with any request -> LOCKED, owner = first requesting index at or after rr_ptr, wrapping at REN.
REQ-022 Grant cycle SHALL accept no flit; earliest head acceptance is the cycle after grant.
REQ-023 in_tready[owner] SHALL be 1 only in LOCKED when output register empty or out_tready=1; all other in_tready bits 0.
REQ-024 Accepted flit (in_tvalid&in_tready) SHALL appear on out_tdata/out_tlast with out_tvalid=1 exactly one cycle later.
REQ-025 Output register SHALL hold data stable while out_tvalid=1 and out_tready=0; cleared when out_tready=1 and no new flit accepted.
REQ-026 Accepting a flit with in_tlast=1 SHALL return FSM to IDLE, set rr_ptr = (owner+1) mod REN, increment pkt_count.
REQ-027 Single-flit packet (head with tlast) SHALL lock and unlock around that one flit.
REQ-028 Owner's in_tvalid low mid-packet SHALL keep LOCKED; no other input granted until tail.
REQ-029 Simultaneous requests SHALL be served round-robin; no input starved beyond REN-1 packets.
REQ-030 Full throughput: one flit per cycle while owner valid and out_tready=1.

Reset
REQ-031 rst=1 SHALL force IDLE, rr_ptr=0, out_tvalid=0, out_tlast=0, out_tdata=0, pkt_count=0, in_tready=0, the next cycle.
REQ-032 Reset mid-packet SHALL drop lock and buffered flit; no partial flit emitted after reset.

Configuration
REQ-033 Macro ROUTER_YX_FIRST_EN defined: route SHALL be Y-first (dest_Y<ROUTER_Y -> 1; > -> 3; else dest_X> -> 2; < -> 4; else 0).
REQ-034 ROUTER_YX_FIRST_EN undefined: X-first routing per REQ-019; all other behaviour identical.

Verification
REQ-035 ROUTER=(1,1), OUT_DIR=2, input 0 sends 3-flit packet dest (2,1) -> grant next cycle, 3 flits out in order, out_tlast on 3rd, pkt_count=1.
REQ-036 Inputs 1 and 3 request simultaneously, rr_ptr=0 -> input 1 packet fully out, then input 3; rr_ptr ends at 4.
REQ-037 out_tready held 0 for 4 cycles mid-packet -> out_tdata stable, owner in_tready=0, no flit lost or duplicated.
REQ-038 Dest (2,0) at ROUTER=(1,1): OUT_DIR=2 instance forwards without macro; OUT_DIR=1 instance forwards with ROUTER_YX_FIRST_EN.
REQ-039 rst asserted after 2nd of 4 flits -> next cycle out_tvalid=0, IDLE, pkt_count=0; new packet then routes normally.
REQ-040 Single-flit packet from input 4 dest (1,1), OUT_DIR=0 -> one flit out with out_tlast=1, FSM back to IDLE, rr_ptr=0.
